// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, jump control codes,
// jump sequencer states and exception causes.
package riscv_pkg;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] JC_JAL  = 2'b01;
  localparam logic [1:0] JC_JALR = 2'b10;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RS1_WAIT,
    S_REDIRECT,
    S_WRITEBACK
  } jstate_e;

endpackage

// File: rtl/jump_target_calc.sv
// Combinational JAL/JALR target, link address and
// misalignment flag.
module jump_target_calc
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      ctrl,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [20:0]     imm,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misaligned
);

  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] lsb_clr;

  always_comb begin
    imm_j   = {{(XLEN-21){imm[20]}}, imm};
    imm_i   = {{(XLEN-12){imm[11]}}, imm[11:0]};
    lsb_clr = {{(XLEN-1){1'b1}}, 1'b0};
    if (ctrl == JC_JALR) begin
      sum = (rs1 + imm_i) & lsb_clr;
    end else begin
      sum = pc + imm_j;
    end
    target     = sum;
    link       = pc + XLEN'(4);
    misaligned = sum[1];
  end

endmodule

// File: rtl/jump_ctrl_fsm.sv
// JAL/JALR sequencer: rs1 fetch, PC redirect with flush,
// link writeback and misaligned/illegal exceptions.
module jump_ctrl_fsm
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      jump_control_i,
  input  logic [4:0]      rd_i,
  input  logic [20:0]     imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            rs1_req_o,
  input  logic            rs1_valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            exc_o,
  output logic [1:0]      exc_cause_o
);

  jstate_e state, state_d;

  logic [4:0]      rd_q;
  logic [20:0]     imm_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] link_q;
  logic [XLEN-1:0] target_q;
  logic            exc_q, exc_d;
  logic [1:0]      cause_q, cause_d;
  logic            ld_cap;
  logic            ld_tgt;

  logic            idle;
  logic [1:0]      c_ctrl;
  logic [XLEN-1:0] c_pc;
  logic [20:0]     c_imm;
  logic [XLEN-1:0] c_target;
  logic [XLEN-1:0] c_link;
  logic            c_mis;

  // Outside IDLE only the JALR completion uses the calculator.
  assign idle   = (state == S_IDLE);
  assign c_ctrl = idle ? jump_control_i : JC_JALR;
  assign c_pc   = idle ? pc_i : pc_q;
  assign c_imm  = idle ? imm_i : imm_q;

  jump_target_calc #(
    .XLEN(XLEN)
  ) u_calc (
    .ctrl      (c_ctrl),
    .pc        (c_pc),
    .rs1       (rs1_data_i),
    .imm       (c_imm),
    .target    (c_target),
    .link      (c_link),
    .misaligned(c_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    exc_d   = 1'b0;
    cause_d = cause_q;
    ld_cap  = 1'b0;
    ld_tgt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (valid_i) begin
          ld_cap = 1'b1;
          unique case (1'b1)
            (jump_control_i == JC_JAL): begin
              ld_tgt = 1'b1;
              if (c_mis) begin
                exc_d   = 1'b1;
                cause_d = CAUSE_MISALIGN;
              end else begin
                state_d = S_REDIRECT;
              end
            end
            (jump_control_i == JC_JALR): begin
              state_d = S_RS1_WAIT;
            end
            default: begin
              exc_d   = 1'b1;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      S_RS1_WAIT: begin
        if (rs1_valid_i) begin
          ld_tgt = 1'b1;
          if (c_mis) begin
            exc_d   = 1'b1;
            cause_d = CAUSE_MISALIGN;
            state_d = S_IDLE;
          end else begin
            state_d = S_REDIRECT;
          end
        end
      end
      S_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = (rd_q == 5'd0) ? S_IDLE : S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (wb_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      link_q   <= '0;
      target_q <= '0;
      exc_q    <= 1'b0;
      cause_q  <= '0;
    end else begin
      exc_q   <= exc_d;
      cause_q <= cause_d;
      if (ld_cap) begin
        rd_q   <= rd_i;
        imm_q  <= imm_i;
        pc_q   <= pc_i;
        link_q <= c_link;
      end
      if (ld_tgt) begin
        target_q <= c_target;
      end
    end
  end

  assign ready_o          = idle;
  assign rs1_req_o        = (state == S_RS1_WAIT);
  assign redirect_valid_o = (state == S_REDIRECT);
  assign flush_o          = redirect_valid_o & redirect_ready_i;
  assign redirect_pc_o    = target_q;
  assign wb_valid_o       = (state == S_WRITEBACK);
  assign wb_rd_o          = rd_q;
  assign wb_data_o        = link_q;
  assign exc_o            = exc_q;
  assign exc_cause_o      = cause_q;

endmodule

// File: tb/tb_jump_ctrl_fsm.sv
// Directed bench for jump_ctrl_fsm: JAL, JALR, misalign,
// backpressure, illegal code, reset abort and wrap.
module tb_jump_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  jump_control_i;
  logic [4:0]  rd_i;
  logic [20:0] imm_i;
  logic [31:0] pc_i;
  logic        rs1_req_o;
  logic        rs1_valid_i;
  logic [31:0] rs1_data_i;
  logic        redirect_valid_o;
  logic        redirect_ready_i;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_o;
  logic [1:0]  exc_cause_o;

  int n_tests;
  int n_fail;

  jump_ctrl_fsm #(.XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .jump_control_i  (jump_control_i),
    .rd_i            (rd_i),
    .imm_i           (imm_i),
    .pc_i            (pc_i),
    .rs1_req_o       (rs1_req_o),
    .rs1_valid_i     (rs1_valid_i),
    .rs1_data_i      (rs1_data_i),
    .redirect_valid_o(redirect_valid_o),
    .redirect_ready_i(redirect_ready_i),
    .redirect_pc_o   (redirect_pc_o),
    .flush_o         (flush_o),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_rd_o         (wb_rd_o),
    .wb_data_o       (wb_data_o),
    .exc_o           (exc_o),
    .exc_cause_o     (exc_cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [1:0] ctrl,
                       input logic [31:0] pc,
                       input logic [20:0] imm,
                       input logic [4:0] rd);
    valid_i        = 1'b1;
    jump_control_i = ctrl;
    pc_i           = pc;
    imm_i          = imm;
    rd_i           = rd;
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    valid_i          = 1'b0;
    jump_control_i   = 2'b00;
    rd_i             = 5'd0;
    imm_i            = 21'd0;
    pc_i             = 32'd0;
    rs1_valid_i      = 1'b0;
    rs1_data_i       = 32'd0;
    redirect_ready_i = 1'b1;
    wb_ready_i       = 1'b1;

    tick();
    tick();
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_redir", 32'(redirect_valid_o), 32'd0);
    check("rst_pc", redirect_pc_o, 32'd0);
    check("rst_wbdata", wb_data_o, 32'd0);
    check("rst_exc", 32'(exc_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // JAL basic
    issue(2'b01, 32'h100, 21'h00010, 5'd1);
    settle();
    check("jal_c0_ready", 32'(ready_o), 32'd1);
    check("jal_c0_redir", 32'(redirect_valid_o), 32'd0);
    tick();
    valid_i = 1'b0;
    settle();
    check("jal_c1_redir", 32'(redirect_valid_o), 32'd1);
    check("jal_c1_pc", redirect_pc_o, 32'h110);
    check("jal_c1_flush", 32'(flush_o), 32'd1);
    check("jal_c1_ready", 32'(ready_o), 32'd0);
    tick();
    check("jal_c2_wbv", 32'(wb_valid_o), 32'd1);
    check("jal_c2_rd", 32'(wb_rd_o), 32'd1);
    check("jal_c2_data", wb_data_o, 32'h104);
    check("jal_c2_flush", 32'(flush_o), 32'd0);
    tick();
    check("jal_c3_ready", 32'(ready_o), 32'd1);
    check("jal_c3_wbv", 32'(wb_valid_o), 32'd0);

    // JALR with rs1 delayed by three cycles
    issue(2'b10, 32'h200, 21'h00FFC, 5'd5);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("jalr_req", 32'(rs1_req_o), 32'd1);
      check("jalr_noredir", 32'(redirect_valid_o), 32'd0);
      tick();
    end
    rs1_valid_i = 1'b1;
    rs1_data_i  = 32'h1001;
    settle();
    check("jalr_req_hs", 32'(rs1_req_o), 32'd1);
    tick();
    rs1_valid_i = 1'b0;
    rs1_data_i  = 32'hDEAD_BEEF;
    settle();
    check("jalr_redir", 32'(redirect_valid_o), 32'd1);
    check("jalr_pc", redirect_pc_o, 32'h0FFC);
    check("jalr_req_off", 32'(rs1_req_o), 32'd0);
    tick();
    check("jalr_wbv", 32'(wb_valid_o), 32'd1);
    check("jalr_rd", 32'(wb_rd_o), 32'd5);
    check("jalr_data", wb_data_o, 32'h204);
    tick();
    check("jalr_ready", 32'(ready_o), 32'd1);

    // JAL misaligned target
    issue(2'b01, 32'h0, 21'h00006, 5'd3);
    tick();
    valid_i = 1'b0;
    settle();
    check("mis_exc", 32'(exc_o), 32'd1);
    check("mis_cause", 32'(exc_cause_o), 32'd1);
    check("mis_redir", 32'(redirect_valid_o), 32'd0);
    check("mis_wbv", 32'(wb_valid_o), 32'd0);
    check("mis_ready", 32'(ready_o), 32'd1);
    tick();
    check("mis_exc_off", 32'(exc_o), 32'd0);
    check("mis_cause_hold", 32'(exc_cause_o), 32'd1);
    check("mis_wbv2", 32'(wb_valid_o), 32'd0);

    // JAL rd=0 with redirect backpressure
    redirect_ready_i = 1'b0;
    issue(2'b01, 32'h40, 21'h00020, 5'd0);
    tick();
    valid_i = 1'b0;
    pc_i    = 32'h1234;
    imm_i   = 21'h00100;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_redir", 32'(redirect_valid_o), 32'd1);
      check("bp_pc", redirect_pc_o, 32'h60);
      check("bp_flush", 32'(flush_o), 32'd0);
      tick();
    end
    redirect_ready_i = 1'b1;
    settle();
    check("bp_flush_hs", 32'(flush_o), 32'd1);
    check("bp_pc_hs", redirect_pc_o, 32'h60);
    tick();
    check("bp_ready", 32'(ready_o), 32'd1);
    check("bp_wbv", 32'(wb_valid_o), 32'd0);
    check("bp_flush_off", 32'(flush_o), 32'd0);

    // Illegal control code, then reset abort in REDIRECT
    issue(2'b11, 32'h300, 21'h00010, 5'd7);
    tick();
    check("ill_exc", 32'(exc_o), 32'd1);
    check("ill_cause", 32'(exc_cause_o), 32'd2);
    check("ill_ready", 32'(ready_o), 32'd1);
    check("ill_redir", 32'(redirect_valid_o), 32'd0);
    redirect_ready_i = 1'b0;
    issue(2'b01, 32'h400, 21'h00010, 5'd9);
    tick();
    valid_i = 1'b0;
    check("abort_pre", 32'(redirect_valid_o), 32'd1);
    check("abort_pre_exc", 32'(exc_o), 32'd0);
    #2;
    rst_n = 1'b0;
    settle();
    check("abort_redir", 32'(redirect_valid_o), 32'd0);
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_pc", redirect_pc_o, 32'd0);
    check("abort_wbv", 32'(wb_valid_o), 32'd0);
    check("abort_cause", 32'(exc_cause_o), 32'd0);
    tick();
    rst_n            = 1'b1;
    redirect_ready_i = 1'b1;
    tick();
    check("abort_after", 32'(redirect_valid_o), 32'd0);

    // Wraparound of target and link
    issue(2'b01, 32'hFFFF_FFFC, 21'h00008, 5'd2);
    tick();
    valid_i = 1'b0;
    settle();
    check("wrap_pc", redirect_pc_o, 32'h4);
    check("wrap_redir", 32'(redirect_valid_o), 32'd1);
    tick();
    check("wrap_link", wb_data_o, 32'h0);
    check("wrap_rd", 32'(wb_rd_o), 32'd2);
    tick();
    check("wrap_ready", 32'(ready_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
